bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter using reverse double dabble: right shifts with a subtract-3 correction on each digit. It takes a packed multi-digit BCD value, such as hours, minutes or seconds entered in time-set mode, and returns its binary value for loading into the clock's binary counters. It is the inverse of the display path's binary-to-BCD conversion. It uses one conversion engine, a start/busy/done handshake and one bit per cycle.

---
 rtl/bcd_to_bin_seq.sv | 139 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double dabble).
// One bit per cycle: {D,R} shifts right, then each D digit >= 8 loses 3.
// Optional macro BCD2BIN_CHECK_EN: flag input digits above 9 via err
// (result forced to 0); when undefined err is tied low.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int unsigned RW = 4 * DIGITS;
  localparam int unsigned NW = $clog2(RW);
  localparam logic [NW-1:0] N_LAST = NW'(RW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [RW-1:0]      d, d_nxt;
  logic [RW-1:0]      r, r_nxt;
  logic [NW-1:0]      n, n_nxt;
  logic               busy_nxt, done_nxt;
  logic [BIN_W-1:0]   bin_nxt;
  logic [RW-1:0]      d_sh, d_fix, r_sh;

`ifdef BCD2BIN_CHECK_EN
  logic               err_q, err_nxt;
  logic               err_pend, err_pend_nxt;
  logic               bad_c;

  // Any input digit above 9 marks the conversion as invalid.
  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_c = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // One datapath step: shift {D,R} right, then correct D digits in parallel.
  always_comb begin
    d_sh  = {1'b0, d[RW-1:1]};
    r_sh  = {d[0], r[RW-1:1]};
    d_fix = d_sh;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (d_sh[4*i+3]) d_fix[4*i +: 4] = d_sh[4*i +: 4] - 4'd3;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    d_nxt     = d;
    r_nxt     = r;
    n_nxt     = n;
    bin_nxt   = bin;
`ifdef BCD2BIN_CHECK_EN
    err_nxt      = err_q;
    err_pend_nxt = err_pend;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          d_nxt     = bcd;
          r_nxt     = '0;
          n_nxt     = '0;
          state_nxt = SHIFT;
`ifdef BCD2BIN_CHECK_EN
          err_pend_nxt = bad_c;
`endif
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        d_nxt = d_fix;
        r_nxt = r_sh;
        n_nxt = n + NW'(1);
        if (n == N_LAST) begin
          state_nxt = DONE;
`ifdef BCD2BIN_CHECK_EN
          bin_nxt = err_pend ? '0 : BIN_W'(r_sh);
          err_nxt = err_pend;
`else
          bin_nxt = BIN_W'(r_sh);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == SHIFT);
    done_nxt = (state_nxt == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      d     <= '0;
      r     <= '0;
      n     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
`ifdef BCD2BIN_CHECK_EN
      err_q    <= 1'b0;
      err_pend <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      d     <= d_nxt;
      r     <= r_nxt;
      n     <= n_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      bin   <= bin_nxt;
`ifdef BCD2BIN_CHECK_EN
      err_q    <= err_nxt;
      err_pend <= err_pend_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq with directed vectors (default params).
module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] bcd;
  logic       busy;
  logic       done;
  logic [6:0] bin;
  logic       err;

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] bin;
    logic       err;
    int         dcyc;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         busy_lo = 0;
  int         busy_hi = 0;
  logic       mon_en = 1'b0;
  logic [6:0] hold_bin = '0;
  logic       hold_err = 1'b0;
  logic       prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: busy window, done pulse, scoreboard pop, held outputs.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", int'(busy), int'(cyc > busy_lo && cyc <= busy_hi));
      if (done) begin
        chk("done_width", int'(prev_done), 0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bin", int'(bin), int'(e.bin));
          chk("err", int'(err), int'(e.err));
          chk("done_cycle", cyc, e.dcyc);
          hold_bin = e.bin;
          hold_err = e.err;
        end
      end else begin
        chk("bin_hold", int'(bin), int'(hold_bin));
        chk("err_hold", int'(err), int'(hold_err));
      end
      prev_done = done;
    end
    if (!rst_n) begin
      hold_bin  = '0;
      hold_err  = 1'b0;
      prev_done = 1'b0;
      q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] v, input logic [6:0] eb, input logic ee);
    exp_t e;
    e.bin  = eb;
    e.err  = ee;
    e.dcyc = cyc + 9;
    q.push_back(e);
    busy_lo = cyc;
    busy_hi = cyc + 8;
    start = 1'b1;
    bcd   = v;
    tick();
    start = 1'b0;
    bcd   = 8'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    if (q.size() != 0) chk("timeout", 1, 0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_bin", int'(bin), 0);
      chk("idle_err", int'(err), 0);
      tick();
    end

    // Boundary values
    issue(8'h00, 7'd0, 1'b0);  wait_idle();
    issue(8'h59, 7'd59, 1'b0); wait_idle();
    issue(8'h99, 7'd99, 1'b0); wait_idle();
    issue(8'h01, 7'd1, 1'b0);  wait_idle();
    issue(8'h80, 7'd80, 1'b0); wait_idle();

    // Start while busy is ignored
    issue(8'h23, 7'd23, 1'b0);
    repeat (3) tick();
    start = 1'b1;
    bcd   = 8'h45;
    tick();
    start = 1'b0;
    wait_idle();
    repeat (10) tick();

    // Back-to-back: second start in the done cycle
    issue(8'h12, 7'd12, 1'b0);
    repeat (8) tick();
    issue(8'h34, 7'd34, 1'b0);
    wait_idle();

`ifdef BCD2BIN_CHECK_EN
    issue(8'h3A, 7'd0, 1'b1); wait_idle();
`endif
    issue(8'h07, 7'd7, 1'b0); wait_idle();

    // Reset mid-conversion
    issue(8'h77, 7'd77, 1'b0);
    repeat (4) tick();
    rst_n   = 1'b0;
    busy_hi = cyc;
    tick();
    rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin", int'(bin), 0);
    chk("rst_err", int'(err), 0);
    repeat (10) tick();
    issue(8'h10, 7'd10, 1'b0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
